svm_classifier: RTL and testbench
=================================

# svm_classifier

Downstream consumer of the deskew stage: after deskew signals completion, this block reads the 784-pixel deskewed image from the shared image memory (upper half, base 784), evaluates a degree-3 polynomial-kernel SVM decision function against `SV_NUM` support vectors held in a separate read-only memory, and returns a signed Q.14 score. It uses the same start/ready/done_interrupt control style and 1-cycle-latency memory reads as the deskew stage.

## Interface
- `WIDTH`, 16, pixel/SV/lambda/bias word width; signed Q.14, one = 16384
- `IMG_SIZE`, 784, pixels per image
- `IMG_BASE`, 784, image-memory address of deskewed pixel 0
- `SV_NUM`, 64, support-vector count (≥1)
- `SV_ADDR_W`, 16, SV-memory address width (≥ clog2(SV_NUM·IMG_SIZE))
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `start` in 1: begin classification; sampled only in IDLE
- `ready` out 1: high only in IDLE
- `done_interrupt` out 1: one-cycle pulse, result valid
- `img_address` out 11: image-memory read address
- `img_en` out 1: image read enable
- `img_data` in WIDTH: pixel, valid the cycle after `img_en`
- `sv_address` out SV_ADDR_W: SV read address = sv_idx·IMG_SIZE + pix
- `sv_en` out 1: SV read enable
- `sv_data` in WIDTH: SV element, 1-cycle latency
- `lambda_address` out clog2(SV_NUM): coefficient (αᵢ·yᵢ) address
- `lambda_en` out 1: coefficient read enable
- `lambda_data` in WIDTH: coefficient, 1-cycle latency
- `bias` in WIDTH: decision bias, sampled in BIAS state
- `result` out 2·WIDTH: signed Q.14 score, held until next BIAS state

## Operation
- Reset: state IDLE; `result`=0, all enables 0, `done_interrupt`=0, `ready`=1, all accumulators/counters 0.
- IDLE: `ready`=1; on `start` clear score_acc, sv_idx=0 → CLR. `start` outside IDLE ignored.
- CLR: dot_acc=0, pix=0 → DOT.
- DOT (IMG_SIZE+1 cycles): if pix<IMG_SIZE assert `img_en`,`sv_en`, `img_address`=IMG_BASE+pix, `sv_address`=sv_idx·IMG_SIZE+pix; if pix>0 dot_acc += img_data·sv_data (signed 32-bit product, 42-bit signed acc). pix++; at pix==IMG_SIZE → KSQ.
- KSQ: t = (dot_acc>>>14) + one, 28-bit signed; t2 = (t·t)>>>14, 28-bit → KCUBE.
- KCUBE: k = (t2·t)>>>14, 28-bit → LRD.
- LRD: `lambda_en`=1, `lambda_address`=sv_idx → LACC.
- LACC: score_acc += (lambda_data·k)>>>14 (42-bit signed); if sv_idx==SV_NUM-1 → BIAS else sv_idx++, → CLR.
- BIAS: `result` = sat₃₂(score_acc + sign-extended bias) → DONE.
- DONE: `done_interrupt`=1 → IDLE.
- Reset asserted mid-run: immediate return to IDLE, run abandoned, `result` cleared.
- Never writes either memory; all enables low outside DOT/LRD.

## Timing
- Per support vector: IMG_SIZE+6 cycles (CLR 1, DOT IMG_SIZE+1, KSQ, KCUBE, LRD, LACC).
- `done_interrupt` high in the cycle starting SV_NUM·(IMG_SIZE+6)+1 edges after the edge sampling `start`; `ready` high the following cycle.
- Default config: 64·790+1 = 50561 cycles.
- `start` held high through DONE launches a new run from IDLE the next cycle (back-to-back, one IDLE cycle).

## Configuration
- `SVM_SATURATE_EN` defined: every narrowing step (t, t2, k, lambda·k term, result) saturates to signed range of target width.
- Undefined: narrowing truncates (two's-complement wrap); `result` still 2·WIDTH LSBs of the sum.

## Structure
- Package `svm_pkg`: state enum (IDLE, CLR, DOT, KSQ, KCUBE, LRD, LACC, BIAS, DONE), `ONE_Q14` constant, fraction-bit constant 14, saturate/truncate function guarded by the macro.
- One sub-module `svm_poly3_kernel`: combinational/registered t→t2→k arithmetic used in KSQ/KCUBE.

## Test plan
- IMG_SIZE=4, SV_NUM=2; pixels 16384, SVs all 0, lambdas 16384, bias −16384 → `result`=16384, done after 2·10+1 = 21 cycles.
- IMG_SIZE=4, SV_NUM=1; pixels 16384, SV 4096 each (dot=1.0), lambda 8192 → k=131072, `result`=65536.
- Negative lambda −16384 with k=one, bias 0 → `result`=−16384 (0xFFFFC000).
- `SVM_SATURATE_EN`, IMG_SIZE=784, SV_NUM=1, pixels and SV 16384, lambda 16384, bias 0 → t2, k clamp to 134217727; `result`=134217727.
- Reset pulsed mid-DOT → enables drop immediately, `result`=0, `ready`=1; next `start` produces correct score.
- `start` pulsed during DOT → ignored; exactly one `done_interrupt` per accepted start; address sequence IMG_BASE..IMG_BASE+IMG_SIZE−1 checked per SV.

Source files
------------

// File: rtl/svm_pkg.sv
`default_nettype none
// svm_pkg: classifier states, Q.14 constants and the narrowing helper.
// Rev 1.0 -- SVM_SATURATE_EN selects saturating (defined) or wrapping (undefined) narrowing.
package svm_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    CLR   = 4'd1,
    DOT   = 4'd2,
    KSQ   = 4'd3,
    KCUBE = 4'd4,
    LRD   = 4'd5,
    LACC  = 4'd6,
    BIAS  = 4'd7,
    DONE  = 4'd8
  } state_t;

  localparam int FRAC_BITS = 14;
  localparam int ONE_Q14   = 1 << FRAC_BITS;
  localparam int KERN_W    = 28;
  localparam int ACC_W     = 42;

  // Reduce a wide signed intermediate to the signed range of 'bits' bits.
  function automatic logic signed [63:0] narrow(input logic signed [63:0] v, input int bits);
`ifdef SVM_SATURATE_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    return (v <<< (64 - bits)) >>> (64 - bits);
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/svm_poly3_kernel.sv
`default_nettype none
// svm_poly3_kernel: registered t -> t^2 -> t^3 chain of the (x.sv + 1)^3 kernel in Q.14.
// Rev 1.0 -- narrowing behaviour follows SVM_SATURATE_EN through svm_pkg::narrow.
module svm_poly3_kernel
  import svm_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ksq_en,
  input  logic                     kcube_en,
  input  logic [ACC_W-1:0]         dot_acc,
  output logic signed [KERN_W-1:0] k
);

  logic signed [KERN_W-1:0] t;
  logic signed [KERN_W-1:0] t2;
  logic signed [KERN_W-1:0] t_n;
  logic signed [KERN_W-1:0] t2_n;
  logic signed [KERN_W-1:0] k_n;

  // t2 is formed from the freshly computed t so both land in the same KSQ cycle.
  assign t_n  = KERN_W'(narrow(64'(signed'(dot_acc) >>> FRAC_BITS) + 64'(ONE_Q14), KERN_W));
  assign t2_n = KERN_W'(narrow((64'(t_n) * 64'(t_n)) >>> FRAC_BITS, KERN_W));
  assign k_n  = KERN_W'(narrow((64'(t2) * 64'(t)) >>> FRAC_BITS, KERN_W));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t  <= '0;
      t2 <= '0;
      k  <= '0;
    end else begin
      if (ksq_en) begin
        t  <= t_n;
        t2 <= t2_n;
      end
      if (kcube_en) begin
        k <= k_n;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/svm_classifier.sv
`default_nettype none
// svm_classifier: degree-3 polynomial-kernel SVM score over a deskewed 784-pixel image.
// Rev 1.0 -- optional SVM_SATURATE_EN makes every narrowing step saturate instead of wrap.
module svm_classifier
  import svm_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int IMG_SIZE  = 784,
  parameter int IMG_BASE  = 784,
  parameter int SV_NUM    = 64,
  parameter int SV_ADDR_W = 16,
  parameter int LAMBDA_AW = (SV_NUM > 1) ? $clog2(SV_NUM) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   ready,
  output logic                   done_interrupt,
  output logic [10:0]            img_address,
  output logic                   img_en,
  input  logic [WIDTH-1:0]       img_data,
  output logic [SV_ADDR_W-1:0]   sv_address,
  output logic                   sv_en,
  input  logic [WIDTH-1:0]       sv_data,
  output logic [LAMBDA_AW-1:0]   lambda_address,
  output logic                   lambda_en,
  input  logic [WIDTH-1:0]       lambda_data,
  input  logic [WIDTH-1:0]       bias,
  output logic [2*WIDTH-1:0]     result
);

  localparam int PIX_W = $clog2(IMG_SIZE + 1);
  localparam int RES_W = 2 * WIDTH;

  state_t state;
  state_t state_n;

  logic [PIX_W-1:0]          pix;
  logic [LAMBDA_AW-1:0]      sv_idx;
  logic signed [ACC_W-1:0]   dot_acc;
  logic signed [ACC_W-1:0]   score_acc;
  logic signed [RES_W-1:0]   prod;
  logic signed [ACC_W-1:0]   term;
  logic signed [RES_W-1:0]   res_n;
  logic signed [KERN_W-1:0]  k;
  logic                      ksq_en;
  logic                      kcube_en;
  logic                      last_sv;

  assign last_sv        = (sv_idx == LAMBDA_AW'(SV_NUM - 1));
  assign img_address    = 11'(IMG_BASE) + 11'(pix);
  assign sv_address     = SV_ADDR_W'(sv_idx) * SV_ADDR_W'(IMG_SIZE) + SV_ADDR_W'(pix);
  assign lambda_address = sv_idx;

  assign prod  = signed'(img_data) * signed'(sv_data);
  assign term  = ACC_W'(narrow((64'(signed'(lambda_data)) * 64'(k)) >>> FRAC_BITS, ACC_W));
  assign res_n = RES_W'(narrow(64'(score_acc) + 64'(signed'(bias)), RES_W));

  always_comb begin
    state_n        = state;
    ready          = 1'b0;
    done_interrupt = 1'b0;
    img_en         = 1'b0;
    sv_en          = 1'b0;
    lambda_en      = 1'b0;
    ksq_en         = 1'b0;
    kcube_en       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_n = CLR;
      end
      CLR: state_n = DOT;
      DOT: begin
        // The last DOT cycle only accumulates the product of the final read.
        if (pix < PIX_W'(IMG_SIZE)) begin
          img_en = 1'b1;
          sv_en  = 1'b1;
        end else begin
          state_n = KSQ;
        end
      end
      KSQ: begin
        ksq_en  = 1'b1;
        state_n = KCUBE;
      end
      KCUBE: begin
        kcube_en = 1'b1;
        state_n  = LRD;
      end
      LRD: begin
        lambda_en = 1'b1;
        state_n   = LACC;
      end
      LACC: state_n = last_sv ? BIAS : CLR;
      BIAS: state_n = DONE;
      DONE: begin
        done_interrupt = 1'b1;
        state_n        = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pix       <= '0;
      sv_idx    <= '0;
      dot_acc   <= '0;
      score_acc <= '0;
      result    <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (start) begin
            score_acc <= '0;
            sv_idx    <= '0;
          end
        end
        CLR: begin
          dot_acc <= '0;
          pix     <= '0;
        end
        DOT: begin
          if (pix != '0) dot_acc <= dot_acc + ACC_W'(prod);
          pix <= pix + PIX_W'(1);
        end
        LACC: begin
          score_acc <= score_acc + term;
          if (!last_sv) sv_idx <= sv_idx + LAMBDA_AW'(1);
        end
        BIAS: result <= res_n;
        default: ;
      endcase
    end
  end

  svm_poly3_kernel u_kernel (
    .clk      (clk),
    .reset    (reset),
    .ksq_en   (ksq_en),
    .kcube_en (kcube_en),
    .dot_acc  (dot_acc),
    .k        (k)
  );

endmodule
`default_nettype wire

// File: tb/tb_svm_classifier.sv
`default_nettype none
// tb_svm_classifier: directed vectors on a 4-pixel/2-SV instance plus a full-size 784-pixel/1-SV instance.
// Rev 1.0
module tb_svm_classifier;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Small instance: IMG_SIZE=4, SV_NUM=2
  logic        s_start = 1'b0;
  logic        s_ready, s_done, s_img_en, s_sv_en, s_lam_en;
  logic [10:0] s_img_addr;
  logic [15:0] s_sv_addr;
  logic [0:0]  s_lam_addr;
  logic [15:0] s_img_q = '0, s_sv_q = '0, s_lam_q = '0, s_bias = '0;
  logic [31:0] s_result;

  // Full-size instance: IMG_SIZE=784, SV_NUM=1, constant 1.0 memories
  logic        b_start = 1'b0;
  logic        b_ready, b_done, b_img_en, b_sv_en, b_lam_en;
  logic [10:0] b_img_addr;
  logic [15:0] b_sv_addr;
  logic [0:0]  b_lam_addr;
  logic [15:0] b_img_q = '0, b_sv_q = '0, b_lam_q = '0;
  logic [31:0] b_result;

  svm_classifier #(.WIDTH(16), .IMG_SIZE(4), .IMG_BASE(784), .SV_NUM(2), .SV_ADDR_W(16)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .ready(s_ready), .done_interrupt(s_done),
    .img_address(s_img_addr), .img_en(s_img_en), .img_data(s_img_q),
    .sv_address(s_sv_addr), .sv_en(s_sv_en), .sv_data(s_sv_q),
    .lambda_address(s_lam_addr), .lambda_en(s_lam_en), .lambda_data(s_lam_q),
    .bias(s_bias), .result(s_result)
  );

  svm_classifier #(.WIDTH(16), .IMG_SIZE(784), .IMG_BASE(784), .SV_NUM(1), .SV_ADDR_W(16)) u_big (
    .clk(clk), .reset(reset), .start(b_start), .ready(b_ready), .done_interrupt(b_done),
    .img_address(b_img_addr), .img_en(b_img_en), .img_data(b_img_q),
    .sv_address(b_sv_addr), .sv_en(b_sv_en), .sv_data(b_sv_q),
    .lambda_address(b_lam_addr), .lambda_en(b_lam_en), .lambda_data(b_lam_q),
    .bias(16'h0000), .result(b_result)
  );

  logic [15:0] img_mem [0:2047];
  logic [15:0] sv_mem  [0:7];
  logic [15:0] lam_mem [0:1];

  always @(posedge clk) begin
    if (s_img_en) s_img_q <= img_mem[s_img_addr];
    if (s_sv_en)  s_sv_q  <= sv_mem[s_sv_addr[2:0]];
    if (s_lam_en) s_lam_q <= lam_mem[s_lam_addr];
    if (b_img_en) b_img_q <= 16'h4000;
    if (b_sv_en)  b_sv_q  <= 16'h4000;
    if (b_lam_en) b_lam_q <= 16'h4000;
  end

  logic [10:0] img_q[$];
  logic [15:0] sv_q[$];
  int          b_img_cnt = 0;

  always @(negedge clk) begin
    if (s_img_en) img_q.push_back(s_img_addr);
    if (s_sv_en)  sv_q.push_back(s_sv_addr);
    if (b_img_en) b_img_cnt = b_img_cnt + 1;
  end

  typedef struct {
    logic [0:3][15:0] pix;
    logic [0:3][15:0] sv0;
    logic [0:3][15:0] sv1;
    logic [15:0]      lam0;
    logic [15:0]      lam1;
    logic [15:0]      bias;
    logic [31:0]      exp_res;
  } vec_t;

  vec_t vecs[5];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load_vec(input int i);
    for (int a = 0; a < 2048; a++) img_mem[a] = 16'h5A5A;
    for (int p = 0; p < 4; p++) begin
      img_mem[784 + p] = vecs[i].pix[p];
      sv_mem[p]        = vecs[i].sv0[p];
      sv_mem[4 + p]    = vecs[i].sv1[p];
    end
    lam_mem[0] = vecs[i].lam0;
    lam_mem[1] = vecs[i].lam1;
    s_bias     = vecs[i].bias;
  endtask

  // Pulse start for one edge, then count edges until done (-1 if the budget expires).
  task automatic run_small(output int cnt);
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    cnt = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (s_done) begin
        cnt = c;
        break;
      end
    end
  endtask

  task automatic check_addr_seq();
    logic ok;
    ok = (img_q.size() == 8) && (sv_q.size() == 8);
    if (ok) begin
      for (int i = 0; i < 8; i++) begin
        if (img_q[i] != 11'(784 + (i % 4))) ok = 1'b0;
        if (sv_q[i] != 16'(i)) ok = 1'b0;
      end
    end
    chk("addr_seq", 64'(ok), 64'd1);
  endtask

  int cnt;
  int done_cnt;
  int first_done;
  int second_done;
  logic [31:0] big_exp;

  initial begin
    vecs[0].pix = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
    vecs[0].sv0 = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[0].sv1 = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[0].lam0 = 16'h4000; vecs[0].lam1 = 16'h4000; vecs[0].bias = 16'hC000;
    vecs[0].exp_res = 32'h0000_4000;

    vecs[1].pix = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
    vecs[1].sv0 = '{16'h1000, 16'h1000, 16'h1000, 16'h1000};
    vecs[1].sv1 = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[1].lam0 = 16'h2000; vecs[1].lam1 = 16'h0000; vecs[1].bias = 16'h0000;
    vecs[1].exp_res = 32'h0001_0000;

    vecs[2].pix = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
    vecs[2].sv0 = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[2].sv1 = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[2].lam0 = 16'hC000; vecs[2].lam1 = 16'h0000; vecs[2].bias = 16'h0000;
    vecs[2].exp_res = 32'hFFFF_C000;

    // SV0 dot=+0.5 -> k=3.375; SV1 dot=-0.5 -> k=0.125, lambda -0.5; bias 100
    vecs[3].pix = '{16'h4000, 16'hC000, 16'h2000, 16'h0000};
    vecs[3].sv0 = '{16'h2000, 16'h2000, 16'h4000, 16'h7FFF};
    vecs[3].sv1 = '{16'hC000, 16'hC000, 16'hC000, 16'hC000};
    vecs[3].lam0 = 16'h4000; vecs[3].lam1 = 16'hE000; vecs[3].bias = 16'h0064;
    vecs[3].exp_res = 32'h0000_D464;

    // Tiny negative dot exercises floor shifts; most-negative bias sign-extends
    vecs[4].pix = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
    vecs[4].sv0 = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
    vecs[4].sv1 = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[4].lam0 = 16'hFFFD; vecs[4].lam1 = 16'h0005; vecs[4].bias = 16'h8000;
    vecs[4].exp_res = 32'hFFFF_8002;

    load_vec(0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(s_ready), 64'd1);
    chk("rst_done", 64'(s_done), 64'd0);
    chk("rst_result", 64'(s_result), 64'd0);
    chk("rst_enables", 64'({s_img_en, s_sv_en, s_lam_en}), 64'd0);
    chk("rst_big_ready", 64'(b_ready), 64'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      load_vec(i);
      img_q.delete();
      sv_q.delete();
      run_small(cnt);
      chk($sformatf("v%0d_latency", i), 64'(cnt), 64'd21);
      chk($sformatf("v%0d_result", i), 64'(s_result), 64'(vecs[i].exp_res));
      check_addr_seq();
      @(posedge clk); #1;
      chk($sformatf("v%0d_ready_after", i), 64'({s_ready, s_done}), 64'b10);
    end

    // start held high: back-to-back runs separated by one IDLE cycle
    load_vec(0);
    first_done = -1;
    second_done = -1;
    s_start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (s_done) begin
        if (first_done < 0) first_done = c;
        else begin
          second_done = c;
          s_start = 1'b0;
          break;
        end
      end
    end
    s_start = 1'b0;
    chk("b2b_first_done", 64'(first_done), 64'd21);
    chk("b2b_second_done", 64'(second_done), 64'd44);
    chk("b2b_result", 64'(s_result), 64'h0000_4000);
    repeat (3) @(posedge clk);
    #1;

    // start pulsed during DOT is ignored
    load_vec(1);
    done_cnt = 0;
    first_done = -1;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      s_start = (c == 3);
      @(posedge clk); #1;
      if (s_done) begin
        done_cnt++;
        if (first_done < 0) first_done = c;
      end
    end
    s_start = 1'b0;
    chk("mid_start_done_count", 64'(done_cnt), 64'd1);
    chk("mid_start_latency", 64'(first_done), 64'd21);
    chk("mid_start_result", 64'(s_result), 64'h0001_0000);

    // asynchronous reset in the middle of DOT
    load_vec(2);
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_img_en", 64'(s_img_en), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("reset_enables", 64'({s_img_en, s_sv_en, s_lam_en}), 64'd0);
    chk("reset_ready", 64'(s_ready), 64'd1);
    chk("reset_result", 64'(s_result), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    img_q.delete();
    sv_q.delete();
    run_small(cnt);
    chk("post_reset_latency", 64'(cnt), 64'd21);
    chk("post_reset_result", 64'(s_result), 64'hFFFF_C000);
    check_addr_seq();

    // full-size image, all ones: kernel overflows 28 bits
`ifdef SVM_SATURATE_EN
    big_exp = 32'd134217727;
`else
    big_exp = 32'hFF0C_4000;
`endif
    b_img_cnt = 0;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    cnt = -1;
    for (int c = 1; c <= 2000; c++) begin
      @(posedge clk); #1;
      if (b_done) begin
        cnt = c;
        break;
      end
    end
    chk("big_latency", 64'(cnt), 64'd791);
    chk("big_result", 64'(b_result), 64'(big_exp));
    chk("big_img_reads", 64'(b_img_cnt), 64'd784);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
